// File: rtl/psu_tmr_pkg.sv
// psu_tmr_pkg: shared types and constants for the PSU sequencing timer bank.
// States, 2MHz preset counts and the select-width helper.
package psu_tmr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } tmr_st_e;

  localparam int unsigned T_100US = 200;
  localparam int unsigned T_10MS  = 20000;
  localparam int unsigned T_50MS  = 100000;
  localparam int unsigned T_1S    = 2000000;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psu_tmr_chan.sv
// psu_tmr_chan: one timer channel (FSM, counter, target/mode latch).
// Optional macro PSU_TMR_TICK_EN gates advance edges with iTick.
module psu_tmr_chan
  import psu_tmr_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic             iOneShot,
  input  logic             iHold,
  input  logic             iTick,
  input  logic [CNT_W-1:0] iTgt,
  output logic             oDone,
  output logic             oBusy
);

  tmr_st_e          st_q, st_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] tgt_q, tgt_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;
  logic             adv;

`ifdef PSU_TMR_TICK_EN
  assign adv = ~iHold & iTick;
`else
  logic unused_tick;
  assign unused_tick = iTick;
  assign adv = ~iHold;
`endif

  // state, counter, latched target/mode and done flag
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      tgt_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      tgt_q  <= tgt_n;
      mode_q <= mode_n;
      done_q <= done_n;
    end
  end

  // next state: enable-low clear wins, then per-state behaviour
  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    tgt_n  = tgt_q;
    mode_n = mode_q;
    done_n = 1'b0;
    if (!iEnable) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else begin
      unique case (1'b1)
        (st_q == ST_IDLE): begin
          st_n   = ST_COUNT;
          cnt_n  = CNT_W'(1);
          tgt_n  = iTgt;
          mode_n = iOneShot;
        end
        (st_q == ST_COUNT): begin
          if (adv) begin
            // >= so a zero target still expires every advance
            if (cnt_q >= tgt_q) begin
              done_n = 1'b1;
              if (mode_q) st_n = ST_DONE;
              else        cnt_n = '0;
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
        end
        (st_q == ST_DONE): begin
          done_n = 1'b1;
        end
        default: begin
          st_n  = ST_IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  assign oDone = done_q;
  assign oBusy = (st_q == ST_COUNT);

endmodule

// File: rtl/psu_seq_timer_bank.sv
// psu_seq_timer_bank: bank of PSU sequencing timers on the 2MHz clock.
// Optional macro PSU_TMR_TICK_EN: advance only on iTick edges.
module psu_seq_timer_bank
  import psu_tmr_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 22,
  parameter int NUM_SEL = 4,
  parameter logic [NUM_SEL*CNT_W-1:0] TGT_TABLE = {
    CNT_W'(T_100US), CNT_W'(T_10MS),
    CNT_W'(T_1S),    CNT_W'(T_50MS)
  },
  localparam int SEL_W = sel_w(NUM_SEL)
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [NUM_CH-1:0]       iEnable,
  input  logic [NUM_CH*SEL_W-1:0] iSel,
  input  logic [NUM_CH-1:0]       iOneShot,
  input  logic [NUM_CH-1:0]       iHold,
  input  logic                    iTick,
  output logic [NUM_CH-1:0]       oDone,
  output logic [NUM_CH-1:0]       oBusy
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SEL_W-1:0] sel_c;
    logic [CNT_W-1:0] tgt_c;

    assign sel_c = iSel[c*SEL_W +: SEL_W];

    // preset lookup; unmatched selects fall back to entry 0
    always_comb begin
      tgt_c = TGT_TABLE[CNT_W-1:0];
      for (int i = 0; i < NUM_SEL; i++) begin
        if (sel_c == SEL_W'(i))
          tgt_c = TGT_TABLE[i*CNT_W +: CNT_W];
      end
    end

    psu_tmr_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iEnable (iEnable[c]),
      .iOneShot(iOneShot[c]),
      .iHold   (iHold[c]),
      .iTick   (iTick),
      .iTgt    (tgt_c),
      .oDone   (oDone[c]),
      .oBusy   (oBusy[c])
    );
  end

endmodule

// File: tb/tb_psu_seq_timer_bank.sv
// tb_psu_seq_timer_bank: directed bench with an edge-count reference model.
// Small preset table keeps runs short: sel0=300 sel1=5000 sel2=50 sel3=200.
module tb_psu_seq_timer_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 22;
  localparam int NUM_SEL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = '0;
  logic [7:0] sel = '0;
  logic [3:0] os = '0;
  logic [3:0] hold = '0;
  logic       tick = 1'b1;
  logic       tick_mode = 1'b0;
  wire  [3:0] done;
  wire  [3:0] busy;

  psu_seq_timer_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .NUM_SEL  (NUM_SEL),
    .TGT_TABLE({22'd200, 22'd50, 22'd5000, 22'd300})
  ) dut (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iEnable (en),
    .iSel    (sel),
    .iOneShot(os),
    .iHold   (hold),
    .iTick   (tick),
    .oDone   (done),
    .oBusy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tbl [4] = '{300, 5000, 50, 200};

  bit act [4];
  bit fin [4];
  bit mode [4];
  int tgt [4];
  int m [4];
  int start [4];
  bit ex_done [4];
  bit ex_busy [4];
  bit prev_done [4];
  int rises [4][$];

  function automatic void chk(string nm, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, want);
    end
  endfunction

  function automatic void chk_rise(string nm, int c, int idx, int want);
    int got;
    got = (rises[c].size() > idx) ? rises[c][idx] : -1;
    chk(nm, got, want);
  endfunction

  function automatic void clr_rises();
    for (int c = 0; c < 4; c++) rises[c].delete();
  endfunction

  // reference: counts advance edges since the enabling edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 4; c++) begin
      automatic bit adv;
      automatic int mm;
      automatic int t1;
      adv = !hold[c];
`ifdef PSU_TMR_TICK_EN
      adv = adv && tick;
`endif
      if (!rst_n || !en[c]) begin
        act[c] <= 1'b0;
        fin[c] <= 1'b0;
        m[c] <= 0;
        ex_done[c] <= 1'b0;
        ex_busy[c] <= 1'b0;
      end else if (!act[c]) begin
        act[c] <= 1'b1;
        fin[c] <= 1'b0;
        tgt[c] <= tbl[sel[c*2 +: 2]];
        mode[c] <= os[c];
        m[c] <= 0;
        start[c] <= cyc + 1;
        ex_done[c] <= 1'b0;
        ex_busy[c] <= 1'b1;
      end else if (fin[c]) begin
        ex_done[c] <= 1'b1;
        ex_busy[c] <= 1'b0;
      end else if (!adv) begin
        ex_done[c] <= 1'b0;
      end else begin
        mm = m[c] + 1;
        m[c] <= mm;
        if (mode[c]) begin
          t1 = (tgt[c] > 0) ? tgt[c] : 1;
          if (mm >= t1) begin
            fin[c] <= 1'b1;
            ex_done[c] <= 1'b1;
            ex_busy[c] <= 1'b0;
          end else begin
            ex_done[c] <= 1'b0;
          end
        end else begin
          ex_done[c] <= (tgt[c] == 0) ||
                        (mm >= tgt[c] && (mm - tgt[c]) % (tgt[c] + 1) == 0);
        end
      end
    end
  end

  // per-cycle compare and rise-time log
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("done%0d", c), int'(done[c]), int'(ex_done[c]));
      chk($sformatf("busy%0d", c), int'(busy[c]), int'(ex_busy[c]));
      if (done[c] && !prev_done[c])
        rises[c].push_back(cyc - start[c]);
      prev_done[c] = done[c];
    end
  end

  // tick source: 1 in 20 cycles when enabled, else always high
  always @(posedge clk) begin
    #2;
    tick = tick_mode ? (cyc % 20 == 0) : 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_out", int'({busy, done}), 0);

    // one-shot T=200
    sel[1:0] = 2'd3;
    os[0] = 1'b1;
    en[0] = 1'b1;
    step(210);
    chk_rise("t1_rise", 0, 0, 200);
    chk("t1_level", int'(done[0]), 1);
    en[0] = 1'b0;
    step(1);
    chk("t1_clr", int'({busy[0], done[0]}), 0);
    step(1);
    clr_rises();

    // periodic T=200
    os[0] = 1'b0;
    en[0] = 1'b1;
    step(610);
    chk("t2_cnt", rises[0].size(), 3);
    chk_rise("t2_p0", 0, 0, 200);
    chk_rise("t2_p1", 0, 1, 401);
    chk_rise("t2_p2", 0, 2, 602);
    en[0] = 1'b0;
    step(2);
    clr_rises();

    // hold for 50 cycles mid-count, then hold in DONE
    os[0] = 1'b1;
    en[0] = 1'b1;
    step(100);
    hold[0] = 1'b1;
    step(50);
    hold[0] = 1'b0;
    step(120);
    chk_rise("t3_rise", 0, 0, 250);
    hold[0] = 1'b1;
    step(10);
    chk("t3_hold_done", int'(done[0]), 1);
    en[0] = 1'b0;
    hold[0] = 1'b0;
    step(2);
    clr_rises();

    // select change mid-count is ignored
    sel[1:0] = 2'd0;
    en[0] = 1'b1;
    step(50);
    sel[1:0] = 2'd1;
    step(270);
    chk_rise("t4_rise", 0, 0, 300);
    chk("t4_cnt", rises[0].size(), 1);
    en[0] = 1'b0;
    step(2);
    clr_rises();

    // staggered channels, reset mid-count
    sel = {2'd2, 2'd3, 2'd3, 2'd3};
    os = 4'b0011;
    en[0] = 1'b1;
    step(10);
    en[1] = 1'b1;
    step(10);
    en[2] = 1'b1;
    step(10);
    en[3] = 1'b1;
    step(70);
    rst_n = 1'b0;
    step(1);
    chk("t5_rst", int'({busy, done}), 0);
    clr_rises();
    rst_n = 1'b1;
    step(230);
    chk_rise("t5_ch0", 0, 0, 200);
    chk_rise("t5_ch1", 1, 0, 200);
    chk_rise("t5_ch2", 2, 0, 200);
    chk_rise("t5_ch3", 3, 0, 50);
    en = '0;
    os = '0;
    step(2);
    clr_rises();

    // tick-qualified counting, T=50
    tick_mode = 1'b1;
    sel[3:2] = 2'd2;
    os[1] = 1'b1;
    en[1] = 1'b1;
    step(1100);
`ifdef PSU_TMR_TICK_EN
    chk("t6_cnt", rises[1].size(), 1);
`else
    chk_rise("t6_rise", 1, 0, 50);
`endif
    en[1] = 1'b0;
    tick_mode = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
